// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide; one iteration per clock edge.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DZERO = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               done_q,   done_d;
  logic               dbz_q,    dbz_d;

  logic               op_signed;
  logic               s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign op_signed = ~op[0];
  assign s1        = op_signed & opr1[WIDTH-1];
  assign s2        = op_signed & opr2[WIDTH-1];
  assign mag1      = s1 ? -opr1 : opr1;
  assign mag2      = s2 ? -opr2 : opr2;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign add_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_next = {add_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  assign trial    = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = trial - {1'b0, a_q};
  assign div_next = {(diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~diff[WIDTH]};

  assign step_next = is_div_q ? div_next : mul_next;
  assign prod      = neg_lo_q ? -step_next : step_next;
  assign quo       = neg_lo_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
  assign rem       = neg_hi_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        // A start is refused while done is showing, so a completion never overlaps an accept.
        if (start && !flush && !done_q) begin
          is_div_d = op[1];
          cnt_d    = '0;
          neg_lo_d = s1 ^ s2;
          if (op[1]) begin
            a_d      = mag2;
            acc_d    = {{WIDTH{1'b0}}, mag1};
            neg_hi_d = s1;
            state_d  = (opr2 == '0) ? S_DZERO : S_BUSY;
          end else begin
            a_d      = mag1;
            acc_d    = {{WIDTH{1'b0}}, mag2};
            neg_hi_d = 1'b0;
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
              hi_d = rem;
              lo_d = quo;
            end else begin
              hi_d = prod[2*WIDTH-1:WIDTH];
              lo_d = prod[WIDTH-1:0];
            end
          end
        end
      end
      S_DZERO: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          dbz_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      a_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opr1 = '0;
  logic [31:0] opr2 = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain wide arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00:   return 64'(sa * sb);
      2'b01:   return ua * ub;
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Issue one op; optionally pulse start mid-run with other operands, which must be ignored.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, input string tag);
    int unsigned cycles;
    bit dz;
    bit early;
    logic [63:0] r;
    dz = o[1] && (b == 32'h0);
    if (!dz) begin
      r = ref_result(o, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    @(negedge clk);
    op = o; opr1 = a; opr2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, 64'(busy), 64'd1);
    cycles = 0;
    early = 1'b0;
    while (busy && cycles < 100) begin
      if (poke && cycles == 5) begin
        start = 1'b1; op = 2'b01; opr1 = 32'h1111; opr2 = 32'h2222;
      end else begin
        start = 1'b0;
      end
      if (done) early = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, "_cycles"}, 64'(cycles), dz ? 64'd1 : 64'd32);
    check({tag, "_early_done"}, 64'(early), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(dz));
    check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] d);
    @(negedge clk);
    wdata = d;
    if (to_hi) hi_we = 1'b1; else lo_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (to_hi) exp_hi = d; else exp_lo = d;
  endtask

  initial begin
    #2;
    check("reset_outputs", {hi, lo}, 64'h0);
    check("reset_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    do_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, "mult_minmin");
    check("mult_minmin_const", {hi, lo}, 64'h40000000_00000000);
    do_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, "mult_neg3x5");
    check("mult_neg3x5_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg7by2");
    check("div_neg7by2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100by7");
    check("divu_100by7_const", {hi, lo}, 64'h00000002_0000000E);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
    check("div_overflow_const", {hi, lo}, 64'h00000000_80000000);

    mt_write(1'b1, 32'h1234);
    mt_write(1'b0, 32'h5678);
    check("mthi_mtlo", {hi, lo}, 64'h00001234_00005678);
    do_op(2'b11, 32'd55, 32'd0, 1'b0, "divu_zero");
    check("divu_zero_keep", {hi, lo}, 64'h00001234_00005678);

    // Flush mid-multiply, then restart straight away.
    @(negedge clk);
    op = 2'b01; opr1 = 32'd3; opr2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_keep", {hi, lo}, {exp_hi, exp_lo});
    do_op(2'b01, 32'd3, 32'd4, 1'b0, "after_flush");
    check("after_flush_const", {hi, lo}, 64'd12);

    // Flush and start together in IDLE: start dropped.
    @(negedge clk);
    op = 2'b01; opr1 = 32'd9; opr2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", 64'(busy), 64'd0);

    do_op(2'b00, 32'd1234567, 32'hFFFF0000, 1'b1, "start_during_busy");

    // MTHI alongside start: the result later overwrites HI.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    op = 2'b01; opr1 = 32'd6; opr2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b0;
    check("mthi_with_start", 64'(hi), 64'hDEADBEEF);
    repeat (32) @(posedge clk);
    #1;
    check("mthi_overwritten", {hi, lo}, 64'd42);
    exp_hi = 32'h0; exp_lo = 32'd42;
    @(posedge clk); #1;

    // Reset mid-divide.
    @(negedge clk);
    op = 2'b10; opr1 = 32'd1000; opr2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid_busy", 64'(busy), 64'd0);
    check("reset_mid_hilo", {hi, lo}, 64'h0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_nodone", 64'(done), 64'd0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(ro, ra, rb, 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
